// File: rtl/cnn16_ram_arbiter.sv
// cnn16_ram_arbiter: two-requester arbiter/sequencer in front of the
// single-port cnn16_ram. Requester A is the CNN compute core, requester B
// is the host/loader port. Each accepted request takes one IDLE cycle for
// selection plus one ACCESS cycle on the RAM, so throughput is one access
// per two cycles. All RAM command signals come straight from registers.
module cnn16_ram_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    // Requester A (compute core)
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    // Requester B (host/loader)
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    // RAM command side
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic                  r_a_gnt;
    logic                  r_b_gnt;
    logic                  r_busy;
    logic                  r_a_rvalid;
    logic                  r_b_rvalid;
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;
    // 1 when B won the most recent grant; reset to B so A wins the first tie
    logic                  r_last_b;
    // Owner of the access currently in ACCESS (1 = B)
    logic                  r_win_b;

    logic                  w_tie_to_a;
    logic                  w_sel_a;
    logic                  w_sel_b;

    // On a tie A wins under fixed priority, otherwise whoever did not win last
    assign w_tie_to_a = (FIXED_PRIO != 0) || r_last_b;
    assign w_sel_a    = a_req && (!b_req || w_tie_to_a);
    assign w_sel_b    = b_req && !w_sel_a;

    // Two-state sequencer: select and register the command in IDLE, run it in ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mem_write <= 1'b0;
            r_address   <= '0;
            r_data_in   <= '0;
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_busy      <= 1'b0;
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_last_b    <= 1'b1;
            r_win_b     <= 1'b0;
        end else begin
            // Read-valid strobes are single-cycle pulses
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_mem_write <= 1'b0;
                    if (w_sel_a || w_sel_b) begin
                        r_address   <= w_sel_a ? a_addr  : b_addr;
                        r_data_in   <= w_sel_a ? a_wdata : b_wdata;
                        r_mem_write <= w_sel_a ? a_we    : b_we;
                        r_a_gnt     <= w_sel_a;
                        r_b_gnt     <= w_sel_b;
                        r_busy      <= 1'b1;
                        r_last_b    <= w_sel_b;
                        r_win_b     <= w_sel_b;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // A read's data is only visible to the owner of the access
                    if (!r_mem_write) begin
                        if (r_win_b) begin
                            r_b_rdata  <= data_out;
                            r_b_rvalid <= 1'b1;
                        end else begin
                            r_a_rdata  <= data_out;
                            r_a_rvalid <= 1'b1;
                        end
                    end
                    r_a_gnt     <= 1'b0;
                    r_b_gnt     <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_write = r_mem_write;
    assign address   = r_address;
    assign data_in   = r_data_in;
    assign a_gnt     = r_a_gnt;
    assign b_gnt     = r_b_gnt;
    assign busy      = r_busy;
    assign a_rvalid  = r_a_rvalid;
    assign b_rvalid  = r_b_rvalid;
    assign a_rdata   = r_a_rdata;
    assign b_rdata   = r_b_rdata;

endmodule

// File: tb/tb_cnn16_ram_arbiter.sv
// Bench for cnn16_ram_arbiter. Two instances share the requester inputs:
// index 0 is round-robin, index 1 is fixed priority. Each has its own
// behavioural RAM (combinational read, write on the rising edge).
module tb_cnn16_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [11:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;

    logic        a_gnt[2], b_gnt[2], a_rvalid[2], b_rvalid[2];
    logic        mem_write[2], busy[2];
    logic [15:0] a_rdata[2], b_rdata[2], data_in[2], data_out[2];
    logic [11:0] address[2];

    logic [15:0] mem0[4096];
    logic [15:0] mem1[4096];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_a, exp_b;

    always #5 clk = ~clk;

    cnn16_ram_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt[0]), .a_rdata(a_rdata[0]), .a_rvalid(a_rvalid[0]),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt[0]), .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]),
        .mem_write(mem_write[0]), .address(address[0]), .data_in(data_in[0]),
        .data_out(data_out[0]), .busy(busy[0])
    );

    cnn16_ram_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt[1]), .a_rdata(a_rdata[1]), .a_rvalid(a_rvalid[1]),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt[1]), .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]),
        .mem_write(mem_write[1]), .address(address[1]), .data_in(data_in[1]),
        .data_out(data_out[1]), .busy(busy[1])
    );

    // RAM models
    always @(posedge clk) begin
        if (mem_write[0]) mem0[address[0]] <= data_in[0];
        if (mem_write[1]) mem1[address[1]] <= data_in[1];
    end
    assign data_out[0] = mem0[address[0]];
    assign data_out[1] = mem1[address[1]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;   // 0 = A, 1 = B
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;  // expected read data (reads only)
    } vec_t;

    vec_t vecs[9];

    // One isolated access: request in T0, grant in T1, read data in T2
    task automatic do_vec(input int idx, input vec_t v);
        @(posedge clk); #1;
        if (!v.port) begin
            a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
        end else begin
            b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("v%0d d%0d a_gnt", idx, d), a_gnt[d], !v.port);
            check($sformatf("v%0d d%0d b_gnt", idx, d), b_gnt[d], v.port);
            check($sformatf("v%0d d%0d mem_write", idx, d), mem_write[d], v.we);
            check($sformatf("v%0d d%0d address", idx, d), address[d], v.addr);
            check($sformatf("v%0d d%0d data_in", idx, d), data_in[d], v.wdata);
            check($sformatf("v%0d d%0d busy", idx, d), busy[d], 1'b1);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk); #1;
        if (!v.we) begin
            if (!v.port) exp_a = v.rdata;
            else         exp_b = v.rdata;
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("v%0d d%0d a_rvalid", idx, d), a_rvalid[d], !v.port && !v.we);
            check($sformatf("v%0d d%0d b_rvalid", idx, d), b_rvalid[d], v.port && !v.we);
            check($sformatf("v%0d d%0d a_rdata", idx, d), a_rdata[d], exp_a);
            check($sformatf("v%0d d%0d b_rdata", idx, d), b_rdata[d], exp_b);
            check($sformatf("v%0d d%0d gnt_low", idx, d), {a_gnt[d], b_gnt[d], mem_write[d], busy[d]}, 4'b0);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 12'h123, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 12'h123, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 12'hFFF, 16'hCAFE, 16'h0000};
        vecs[3] = '{1'b0, 1'b0, 12'hFFF, 16'h0000, 16'hCAFE};
        vecs[4] = '{1'b1, 1'b0, 12'h123, 16'h0000, 16'hBEEF};
        vecs[5] = '{1'b0, 1'b1, 12'h010, 16'h1111, 16'h0000};
        vecs[6] = '{1'b1, 1'b1, 12'h020, 16'h2222, 16'h0000};
        vecs[7] = '{1'b1, 1'b0, 12'h010, 16'h0000, 16'h1111};
        vecs[8] = '{1'b0, 1'b0, 12'h020, 16'h0000, 16'h2222};

        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        exp_a = '0; exp_b = '0;

        // Reset state
        #3;
        check("rst outputs", {a_gnt[0], b_gnt[0], a_rvalid[0], b_rvalid[0], mem_write[0], busy[0]}, 6'b0);
        check("rst address/data_in", {address[0], data_in[0]}, 28'h0);
        check("rst rdata", {a_rdata[0], b_rdata[0]}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle%0d mem_write", i), mem_write[0], 1'b0);
            check($sformatf("idle%0d busy", i), busy[0], 1'b0);
        end

        // Single accesses, including cross-port coherence at 0xFFF
        for (int i = 0; i < 9; i++) do_vec(i, vecs[i]);

        // Reset in the middle of a B write's ACCESS cycle
        @(posedge clk); #1;
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h0AA; b_wdata = 16'h5555;
        @(posedge clk); #1;
        check("midrst pre b_gnt", b_gnt[0], 1'b1);
        check("midrst pre mem_write", mem_write[0], 1'b1);
        #1 rst = 1'b1;
        #1;
        check("midrst mem_write", mem_write[0], 1'b0);
        check("midrst b_gnt", b_gnt[0], 1'b0);
        check("midrst busy", busy[0], 1'b0);
        check("midrst address/data_in", {address[0], data_in[0]}, 28'h0);
        check("midrst rdata", {a_rdata[0], b_rdata[0]}, 32'h0);
        exp_a = '0; exp_b = '0;
        b_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++)
                check($sformatf("postrst%0d d%0d quiet", i, d),
                      {a_gnt[d], b_gnt[d], a_rvalid[d], b_rvalid[d], busy[d]}, 5'b0);
        end

        // Continuous tie: RR alternates A,B,A,B (A first); fixed priority only grants A
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h020;
        for (int k = 1; k <= 8; k++) begin
            automatic logic odd  = (k % 2) == 1;
            automatic logic win_a = (((k - 1) / 2) % 2) == 0;
            @(posedge clk); #1;
            if (!odd) begin
                if (win_a) exp_a = 16'h1111;
                else       exp_b = 16'h2222;
            end
            check($sformatf("rr%0d a_gnt", k), a_gnt[0], odd && win_a);
            check($sformatf("rr%0d b_gnt", k), b_gnt[0], odd && !win_a);
            check($sformatf("rr%0d a_rvalid", k), a_rvalid[0], !odd && win_a);
            check($sformatf("rr%0d b_rvalid", k), b_rvalid[0], !odd && !win_a);
            check($sformatf("rr%0d a_rdata", k), a_rdata[0], exp_a);
            check($sformatf("rr%0d b_rdata", k), b_rdata[0], exp_b);
            check($sformatf("fp%0d a_gnt", k), a_gnt[1], odd);
            check($sformatf("fp%0d b_gnt", k), b_gnt[1], 1'b0);
            check($sformatf("fp%0d a_rvalid", k), a_rvalid[1], !odd);
            check($sformatf("fp%0d a_rdata", k), a_rdata[1], (k >= 2) ? 16'h1111 : 16'h0000);
        end
        a_req = 1'b0;
        @(posedge clk); #1;
        check("fp b_gnt after A drops", b_gnt[1], 1'b1);
        check("fp a_gnt after A drops", a_gnt[1], 1'b0);
        check("rr b_gnt after A drops", b_gnt[0], 1'b1);
        b_req = 1'b0;
        @(posedge clk); #1;
        check("fp b_rvalid", b_rvalid[1], 1'b1);
        check("fp b_rdata", b_rdata[1], 16'h2222);
        check("fp a_rvalid", a_rvalid[1], 1'b0);

        // A request raised during B's ACCESS and dropped before IDLE sampling is withdrawn
        @(posedge clk); #1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h123;
        @(posedge clk); #1;
        check("wd b_gnt", b_gnt[0], 1'b1);
        a_req = 1'b1; a_we = 1'b1; a_addr = 12'h050; a_wdata = 16'hDEAD;
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b0;
        check("wd b_rvalid", b_rvalid[0], 1'b1);
        check("wd b_rdata", b_rdata[0], 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++)
                check($sformatf("wd%0d d%0d no access", i, d), {a_gnt[d], mem_write[d], busy[d]}, 3'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cnn16_ram_arbiter.md
Name: cnn16_ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port cnn16_ram (16-bit data, 4096 words).
- Requester A is the CNN compute core (weights, activations, partial sums). Requester B is the host/loader port (image preload, result readback).
- Serialises accesses, drives the RAM command signals from registers, and returns read data with a valid pulse.
- Round-robin or fixed priority, selected by parameter. One access per two cycles.

Parameters:
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 12, RAM address width.
- FIXED_PRIO, 0: 0 = round-robin between A and B; 1 = A always wins a tie.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  A requests an access; holds request fields stable until a_gnt.
- a_we  in  1  A access type: 1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  A word address.
- a_wdata  in  DATA_WIDTH  A write data.
- a_gnt  out  1  A access is executing this cycle (1-cycle pulse).
- a_rdata  out  DATA_WIDTH  A read data; holds until A's next read completes.
- a_rvalid  out  1  a_rdata updated this cycle (1-cycle pulse, reads only).
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid: same as the A ports, for B.
- mem_write  out  1  RAM write enable.
- address  out  ADDR_WIDTH  RAM address.
- data_in  out  DATA_WIDTH  RAM write data.
- data_out  in  DATA_WIDTH  RAM read data (combinational read of address).
- busy  out  1  arbiter is in ACCESS.

Behaviour:
- Reset (async, rst=1), applied immediately regardless of clk:
  - state=IDLE; mem_write=0; address=0; data_in=0.
  - a_gnt=b_gnt=0; a_rvalid=b_rvalid=0; a_rdata=b_rdata=0; busy=0.
  - last_winner=B, so A wins the first tie.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - mem_write=0; address and data_in hold their last values.
  - If no req: stay in IDLE.
  - If exactly one req: select that requester.
  - If both req: with FIXED_PRIO=1 select A; with FIXED_PRIO=0 select the requester that is not last_winner.
  - On selection, at the clock edge:
    - register address, data_in and mem_write from the winner's addr, wdata and we;
    - set the winner's gnt=1, set busy=1, update last_winner;
    - go to ACCESS.
- ACCESS (exactly 1 cycle):
  - The RAM sees the registered command.
  - A write commits at the closing edge.
  - For a read, data_out is captured into the winner's rdata at the closing edge.
  - At the closing edge: gnt=0, mem_write=0, busy=0, go to IDLE.
  - For a read, the winner's rvalid=1 for the following cycle.
- Latency, with the request first seen in cycle T0:
  - gnt and RAM access in T1.
  - rvalid/rdata in T2.
  - Earliest next grant in T3. Sustained throughput is 1 access per 2 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Deassert req at the edge ending the gnt cycle. req still high in T2 is a new request.
- Starvation: under continuous requests from both sides with FIXED_PRIO=0, grants strictly alternate A, B, A, B.
- rvalid never asserts for writes. rdata of the non-winning port never changes.
- Read-after-write to the same address from either port returns the written value. Accesses are serialised, so there is no hazard.
- A req dropped in IDLE before being granted is treated as withdrawn; no access occurs.
- Reset mid-ACCESS:
  - mem_write drops asynchronously, so a write in flight may be lost. This is acceptable.
  - No gnt or rvalid follows after reset is released.
- Widths: all data paths pass straight through with no arithmetic. Addresses above 4095 are unrepresentable.

Test Plan:
- Reset values: rst=1 mid-run -> all outputs 0 immediately, without waiting for a clock edge. After release with no req, mem_write stays 0 and busy stays 0 for 10 cycles.
- Single write/read on A: A write addr=0x123, wdata=0xBEEF, then A read addr=0x123.
  - Write: a_gnt in T1 with mem_write=1, address=0x123, data_in=0xBEEF.
  - Read: a_rvalid=1 in T2 with a_rdata=0xBEEF; b_rvalid stays 0.
- Tie, round-robin: FIXED_PRIO=0, A and B both request reads continuously from 0x010 and 0x020 (preloaded 0x1111 and 0x2222).
  - Grants alternate A, B, A, B, first grant to A.
  - a_rdata=0x1111, b_rdata=0x2222, one access every 2 cycles.
- Fixed priority: FIXED_PRIO=1, both request continuously -> only A is granted. B is granted in the first IDLE after A drops its req.
- Cross-port coherence: B writes 0xCAFE to 0xFFF, then A reads 0xFFF -> a_rdata=0xCAFE. Address 0xFFF is at the top-of-range boundary.
- Reset mid-ACCESS: assert rst during the ACCESS cycle of a B write.
  - mem_write=0 immediately and b_gnt=0.
  - After release, state=IDLE, no rvalid pulse, and the next tie grants A.
